// File: rtl/expected_delay_line.sv
// Delay line for checker expected values: carries {data, valid} through LATENCY
// clock-enabled stages so the expectation lines up with a DUT of the same latency.
module expected_delay_line #(
    parameter int LATENCY       = 1,
    parameter int EXPECTED_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cke,
    input  logic [EXPECTED_BITS-1:0] s_data,
    input  logic                     s_valid,
    output logic [EXPECTED_BITS-1:0] m_data,
    output logic                     m_valid
);

    if (LATENCY < 0 || EXPECTED_BITS < 1) begin : g_param_check
        $error("expected_delay_line: illegal LATENCY=%0d or EXPECTED_BITS=%0d",
               LATENCY, EXPECTED_BITS);
    end

    if (LATENCY == 0) begin : g_passthru
        // Clock, reset and enable are deliberately ignored in pass-through mode.
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, reset, cke};

        assign m_data  = s_data;
        assign m_valid = s_valid;
    end else if (LATENCY > 0) begin : g_pipe
        logic [EXPECTED_BITS-1:0] data_q  [LATENCY];
        logic [EXPECTED_BITS-1:0] data_d  [LATENCY];
        logic                     valid_q [LATENCY];
        logic                     valid_d [LATENCY];

        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (cke) begin
                data_d[0]  = s_data;
                valid_d[0] = s_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    data_d[i]  = data_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_q  <= '{default: '0};
                valid_q <= '{default: 1'b0};
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign m_data  = data_q[LATENCY-1];
        assign m_valid = valid_q[LATENCY-1];
    end

endmodule

// File: tb/tb_expected_delay_line.sv
// Scoreboard bench for expected_delay_line: one reference FIFO per registered
// instance, with a negedge monitor popping one expected snapshot per clock.
module tb_expected_delay_line;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        cke     = 1'b0;
    logic [63:0] s_data  = '0;
    logic        s_valid = 1'b0;

    logic [7:0]  m_data_l3;
    logic        m_valid_l3;
    logic [7:0]  m_data_l2;
    logic        m_valid_l2;
    logic [7:0]  m_data_l0;
    logic        m_valid_l0;
    logic [0:0]  m_data_l1a;
    logic        m_valid_l1a;
    logic [63:0] m_data_l1b;
    logic        m_valid_l1b;

    expected_delay_line #(.LATENCY(3), .EXPECTED_BITS(8)) u_l3 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
        .m_data(m_data_l3), .m_valid(m_valid_l3));

    expected_delay_line #(.LATENCY(2), .EXPECTED_BITS(8)) u_l2 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
        .m_data(m_data_l2), .m_valid(m_valid_l2));

    expected_delay_line #(.LATENCY(0), .EXPECTED_BITS(8)) u_l0 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
        .m_data(m_data_l0), .m_valid(m_valid_l0));

    expected_delay_line #(.LATENCY(1), .EXPECTED_BITS(1)) u_l1a (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data[0:0]), .s_valid(s_valid),
        .m_data(m_data_l1a), .m_valid(m_valid_l1a));

    expected_delay_line #(.LATENCY(1), .EXPECTED_BITS(64)) u_l1b (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data_l1b), .m_valid(m_valid_l1b));

    always #10 clk = ~clk;

    typedef struct packed {
        logic        v3;
        logic [7:0]  d3;
        logic        v2;
        logic [7:0]  d2;
        logic        v1;
        logic [63:0] d1;
    } exp_t;

    // Reference model: each FIFO holds LATENCY {valid, data} entries; the front is
    // what the outputs must show, and each enabled edge pushes the input and pops one.
    logic [64:0] pipe3 [$];
    logic [64:0] pipe2 [$];
    logic [64:0] pipe1 [$];
    exp_t        exp_q [$];
    exp_t        mon_e;

    int checks   = 0;
    int failures = 0;

    function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void resetModel();
        pipe3.delete();
        pipe2.delete();
        pipe1.delete();
        for (int i = 0; i < 3; i++) pipe3.push_back('0);
        for (int i = 0; i < 2; i++) pipe2.push_back('0);
        pipe1.push_back('0);
    endfunction

    function automatic void shiftModel(logic [64:0] entry);
        pipe3.push_back(entry);
        pipe2.push_back(entry);
        pipe1.push_back(entry);
        void'(pipe3.pop_front());
        void'(pipe2.pop_front());
        void'(pipe1.pop_front());
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.v3 = pipe3[0][64];
        e.d3 = pipe3[0][7:0];
        e.v2 = pipe2[0][64];
        e.d2 = pipe2[0][7:0];
        e.v1 = pipe1[0][64];
        e.d1 = pipe1[0][63:0];
        return e;
    endfunction

    function automatic void checkRegistered(string tag, exp_t e);
        checkOutput({tag, "_l3_valid"},  64'(m_valid_l3),  64'(e.v3));
        checkOutput({tag, "_l3_data"},   64'(m_data_l3),   64'(e.d3));
        checkOutput({tag, "_l2_valid"},  64'(m_valid_l2),  64'(e.v2));
        checkOutput({tag, "_l2_data"},   64'(m_data_l2),   64'(e.d2));
        checkOutput({tag, "_l1w1_valid"},  64'(m_valid_l1a), 64'(e.v1));
        checkOutput({tag, "_l1w1_data"},   64'(m_data_l1a),  64'(e.d1[0]));
        checkOutput({tag, "_l1w64_valid"}, 64'(m_valid_l1b), 64'(e.v1));
        checkOutput({tag, "_l1w64_data"},  m_data_l1b,       e.d1);
    endfunction

    // Monitor: one expected snapshot per clock, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkRegistered("mon", mon_e);
        end
        checkOutput("mon_l0_data",  64'(m_data_l0),  64'(s_data[7:0]));
        checkOutput("mon_l0_valid", 64'(m_valid_l0), 64'(s_valid));
    end

    // Drives one cycle of input (entered at posedge+1) and records the expectation.
    task automatic applyStimulus(input logic [63:0] d, input logic v, input logic c);
        s_data  = d;
        s_valid = v;
        cke     = c;
        @(posedge clk);
        if (!reset)
            resetModel();
        else if (cke)
            shiftModel({s_valid, s_data});
        exp_q.push_back(snapshot());
        #1;
    endtask

    task automatic checkPassThrough(input string tag);
        s_data  = 64'h3C;
        s_valid = 1'b1;
        #1;
        checkOutput({tag, "_l0_data_3c"},  64'(m_data_l0),  64'h3C);
        checkOutput({tag, "_l0_valid_1"},  64'(m_valid_l0), 64'h1);
        s_data  = 64'hC3;
        s_valid = 1'b0;
        #1;
        checkOutput({tag, "_l0_data_c3"},  64'(m_data_l0),  64'hC3);
        checkOutput({tag, "_l0_valid_0"},  64'(m_valid_l0), 64'h0);
    endtask

    // Called at posedge+1: asserts reset mid-cycle and checks the outputs clear at once.
    task automatic asyncReset(input int hold);
        #2;
        reset = 1'b0;
        resetModel();
        #1;
        checkRegistered("async_rst", snapshot());
        exp_q.delete();
        exp_q.push_back(snapshot());
        checkPassThrough("rst_low");
        repeat (hold) applyStimulus({$urandom, $urandom}, 1'b1, 1'b1);
        reset = 1'b1;
    endtask

    // Reset falls on the very edge that would capture a valid entry.
    task automatic resetOnEdge();
        s_data  = {2{32'h7777_7777}};
        s_valid = 1'b1;
        cke     = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        resetModel();
        exp_q.push_back(snapshot());
        #1;
        applyStimulus('0, 1'b0, 1'b1);
        reset = 1'b1;
        repeat (4) applyStimulus('0, 1'b0, 1'b1);
    endtask

    initial begin
        resetModel();
        #1 reset = 1'b0;
        #2;
        checkRegistered("reset_state", snapshot());
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed sequence 0x11/1, 0x22/0, 0x33/1 then flush.
        applyStimulus(64'h11, 1'b1, 1'b1);
        applyStimulus(64'h22, 1'b0, 1'b1);
        applyStimulus(64'h33, 1'b1, 1'b1);
        repeat (4) applyStimulus('0, 1'b0, 1'b1);

        // Enable gating: one entry, four held cycles, then resume.
        applyStimulus(64'hA5, 1'b1, 1'b1);
        repeat (4) applyStimulus(64'h5A, 1'b1, 1'b0);
        repeat (4) applyStimulus('0, 1'b0, 1'b1);

        checkPassThrough("rst_high");

        // Fill every stage with ones, then reset between edges.
        repeat (4) applyStimulus({64{1'b1}}, 1'b1, 1'b1);
        asyncReset(2);
        repeat (4) applyStimulus('0, 1'b0, 1'b1);
        applyStimulus(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
        repeat (4) applyStimulus('0, 1'b0, 1'b1);

        resetOnEdge();

        for (int i = 0; i < 300; i++) begin
            applyStimulus({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            if (i == 120 || i == 240) asyncReset(1 + (i / 120));
        end

        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/expected_delay_line.md
Name: expected_delay_line

Overview:
- Parameterised pipeline delay for testbench expected values.
- Delays a data word and its valid flag by exactly LATENCY clock-enabled cycles, so the expectation lines up with a DUT of the same latency.
- Sits beside the DUT inside assertion/checker modules; the checker compares m_data against the DUT output only when m_valid=1.

Parameters:
- LATENCY, 1, number of cke-qualified pipeline stages; 0 = combinational pass-through; legal range 0..256.
- EXPECTED_BITS, 8, width of s_data/m_data; legal range >=1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cke  input  1  clock enable; stages advance only when cke=1.
- s_data  input  EXPECTED_BITS  expected value entering the delay line.
- s_valid  input  1  expected value is valid/checkable.
- m_data  output  EXPECTED_BITS  s_data delayed LATENCY enabled cycles.
- m_valid  output  1  s_valid delayed LATENCY enabled cycles.

Behaviour:
- LATENCY=0:
  - m_data = s_data and m_valid = s_valid, purely combinational.
  - No registers; reset and cke have no effect.
- LATENCY>=1:
  - Chain of LATENCY stages, each holding {data, valid}.
  - Stage 0 loads {s_data, s_valid}; stage i loads stage i-1.
  - m_data and m_valid are driven from stage LATENCY-1, registered directly with no output logic.
- Advance rule:
  - On rising clk with reset=1 and cke=1, every stage shifts.
  - With cke=0, all stages hold (no shift, no loss, no duplication).
- Data stages shift on every enabled cycle regardless of valid. Data accompanying valid=0 is carried but meaningless.
- Latency is counted in cke=1 edges, not clock cycles. A value entered on enabled edge n appears at the outputs after enabled edge n+LATENCY-1, i.e. it is visible during the cycle following the LATENCY-th enabled edge counted from its entry.
- Reset (reset=0, asynchronous):
  - All valid stages clear to 0 immediately, independent of clk and cke; m_valid=0 at once.
  - All data stages clear to 0; m_data=0.
  - Reset mid-stream discards all in-flight entries; none reappear after release.
- Reset release: synchronous to the next rising clk. The first enabled edge after release loads stage 0 normally.
- Simultaneous reset=0 and cke=1: reset wins.
- Width: no arithmetic; bit-exact transport of EXPECTED_BITS bits. No sign handling.
- Illegal LATENCY (<0) or EXPECTED_BITS (<1): elaboration-time error via $error in an initial/elaboration check.
- X handling: X on s_data propagates unchanged. X on s_valid while reset=1 is propagated (not masked).

Test Plan:
- LATENCY=3, EXPECTED_BITS=8, cke=1:
  - Drive s_data=0x11,0x22,0x33 with s_valid=1,0,1 on consecutive edges.
  - m_data/m_valid = 0x11/1, 0x22/0, 0x33/1 on the 3rd, 4th and 5th edges after entry respectively.
- cke gating, LATENCY=2:
  - Enter 0xA5 valid, then hold cke=0 for 4 cycles, then cke=1.
  - Output stays at its previous value during the hold.
  - 0xA5/1 appears only after the 2nd enabled edge.
- Asynchronous reset:
  - With 0xFF/1 in every stage, pull reset=0 between clock edges.
  - m_valid=0 and m_data=0x00 immediately, before the next edge.
  - After release, 0x00/0 until new valid data traverses LATENCY enabled edges.
- LATENCY=0:
  - Toggle s_data 0x3C→0xC3 and s_valid 1→0 mid-cycle.
  - Outputs follow in the same delta with no clock involvement; reset=0 has no effect.
- LATENCY=1, EXPECTED_BITS=1 and EXPECTED_BITS=64 boundary widths:
  - Random s_data/s_valid stream, cke random 50%.
  - Outputs equal a reference queue popped on each cke=1 edge.
- Reset asserted on the same edge as cke=1 with valid input:
  - Input is not captured; m_valid remains 0 on the following cycles.
